cond_flag_stage: RTL
====================

// Module: cond_flag_stage
// PURPOSE
//  Stage directly downstream of the ALU. Holds the architectural NZCV flags
//  register and evaluates the 4-bit condition field against the flags.
//  Gates the write enables, and registers the ALU result for writeback.
//  One-entry pipeline register with a valid/ready handshake and flush.
//  Also keeps a saturating count of squashed (condition-failed) instructions.
// PARAMETERS
//  N   32  datapath width (ALU result)
//  CW  16  width of squash counter
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   upstream instruction/result valid
//  in_ready   out  1   stage can accept this cycle
//  alu_result in   N   ALU result
//  alu_flags  in   4   [3]N [2]Z [1]C [0]V from ALU
//  cond       in   4   condition code (ARM encoding)
//  flag_w     in   2   [1] update N,Z; [0] update C,V
//  reg_w_in   in   1   register-write request
//  mem_w_in   in   1   memory-write request
//  pc_src_in  in   1   PC-redirect request
//  rd_in      in   4   destination register index
//  flush      in   1   squash: kill held entry and any acceptance this cycle
//  out_valid  out  1   registered entry valid
//  out_ready  in   1   downstream accepts entry
//  out_result out  N   registered alu_result
//  out_rd     out  4   registered rd_in
//  reg_write  out  1   reg_w_in & cond_ex (registered)
//  mem_write  out  1   mem_w_in & cond_ex (registered)
//  pc_src     out  1   pc_src_in & cond_ex (registered)
//  cond_ex    out  1   registered condition-pass of held entry
//  flags      out  4   architectural NZCV register
//  squash_cnt out  CW  saturating count of accepted entries with cond_ex=0
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_valid=0, all out_*/reg_write/mem_write/pc_src/
//    cond_ex=0, flags=4'b0000, squash_cnt=0. rst overrides flush/handshake.
//  - in_ready = ~flush & (~out_valid | out_ready) (combinational).
//  - accept = in_valid & in_ready. Latency 1 cycle: accepted data appears on
//    out_* the next cycle with out_valid=1.
//  - No accept & out_ready & out_valid: out_valid->0 next cycle.
//  - Stall (out_valid & ~out_ready & ~flush): all out_* and flags hold.
//  - Condition uses current flags register (pre-update), not alu_flags:
//    0000 EQ Z | 0001 NE ~Z | 0010 CS C | 0011 CC ~C | 0100 MI N | 0101 PL ~N
//    0110 VS V | 0111 VC ~V | 1000 HI C&~Z | 1001 LS ~C|Z | 1010 GE N==V
//    1011 LT N!=V | 1100 GT ~Z&(N==V) | 1101 LE Z|(N!=V) | 1110 AL 1
//    1111 -> 0 (never)
//  - Flag update on accept & cond pass only: flag_w[1] loads N,Z from
//    alu_flags[3:2]; flag_w[0] loads C,V from alu_flags[1:0]. Failed cond:
//    flags unchanged regardless of flag_w.
//  - Back-to-back: an entry accepted in cycle t sees flags written by entry
//    accepted in cycle t-1 (registered flags, no bypass needed).
//  - squash_cnt +1 on each accept with cond fail; saturates at 2^CW-1.
//  - flush=1: next cycle out_valid=0; in_ready=0 so no accept, no flag or
//    counter update that cycle. Flush with no held entry is harmless.
// TESTING
//  1 rst=1 two cycles -> out_valid=0, flags=0000, squash_cnt=0, in_ready=1.
//  2 accept result=0, alu_flags=0100, cond=1110, flag_w=11, reg_w_in=1 ->
//    next cycle out_valid=1, reg_write=1, flags=0100. Then cond=0000,
//    reg_w_in=1 -> cond_ex=1, reg_write=1.
//  3 flags=0100, cond=0001, reg_w/mem_w/pc_src_in=1, flag_w=11,
//    alu_flags=1000 -> reg_write=mem_write=pc_src=0, flags stay 0100,
//    squash_cnt=1.
//  4 out_valid=1, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0,
//    out_* and flags stable; out_ready=1 -> new entry loaded next cycle.
//  5 flush=1 with in_valid=1, cond=1110, flag_w=11 -> no accept, flags
//    unchanged, out_valid=0 next cycle.
//  6 flags=1000 (N=1,V=0): cond=1011 passes, 1010 and 1100 fail; with CW=4,
//    20 failed accepts -> squash_cnt=15.

Source files
------------

// File: rtl/cond_flag_stage.sv
// Post-ALU stage: holds the architectural NZCV flags, evaluates the condition
// field against them, gates write enables and registers the result for writeback.
module cond_flag_stage #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  alu_result,
  input  logic [3:0]    alu_flags,
  input  logic [3:0]    cond,
  input  logic [1:0]    flag_w,
  input  logic          reg_w_in,
  input  logic          mem_w_in,
  input  logic          pc_src_in,
  input  logic [3:0]    rd_in,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_result,
  output logic [3:0]    out_rd,
  output logic          reg_write,
  output logic          mem_write,
  output logic          pc_src,
  output logic          cond_ex,
  output logic [3:0]    flags,
  output logic [CW-1:0] squash_cnt
);

  logic          r_vld_p1;
  logic [N-1:0]  r_result_p1;
  logic [3:0]    r_rd_p1;
  logic          r_reg_w_p1;
  logic          r_mem_w_p1;
  logic          r_pc_src_p1;
  logic          r_cex_p1;
  logic [3:0]    r_flags;
  logic [CW-1:0] r_squash_cnt;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_pass;

  // ARM condition codes evaluated on {N,Z,C,V}; 1111 never passes.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = cf;
      4'b0011: cond_eval = ~cf;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = cf & ~z;
      4'b1001: cond_eval = ~cf | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    sat_inc = (&x) ? x : x + 1'b1;
  endfunction

  assign w_in_ready = ~flush & (~r_vld_p1 | out_ready);
  assign w_accept   = in_valid & w_in_ready;
  // Condition sees the registered flags, i.e. those written by the previous accept.
  assign w_pass     = cond_eval(cond, r_flags);

  // Stage boundary p0 -> p1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_result_p1  <= '0;
      r_rd_p1      <= '0;
      r_reg_w_p1   <= 1'b0;
      r_mem_w_p1   <= 1'b0;
      r_pc_src_p1  <= 1'b0;
      r_cex_p1     <= 1'b0;
      r_flags      <= 4'b0000;
      r_squash_cnt <= '0;
    end else if (w_accept) begin
      r_vld_p1    <= 1'b1;
      r_result_p1 <= alu_result;
      r_rd_p1     <= rd_in;
      r_reg_w_p1  <= reg_w_in & w_pass;
      r_mem_w_p1  <= mem_w_in & w_pass;
      r_pc_src_p1 <= pc_src_in & w_pass;
      r_cex_p1    <= w_pass;
      if (w_pass) begin
        if (flag_w[1]) r_flags[3:2] <= alu_flags[3:2];
        if (flag_w[0]) r_flags[1:0] <= alu_flags[1:0];
      end else begin
        r_squash_cnt <= sat_inc(r_squash_cnt);
      end
    end else if (flush | out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_vld_p1;
  assign out_result = r_result_p1;
  assign out_rd     = r_rd_p1;
  assign reg_write  = r_reg_w_p1;
  assign mem_write  = r_mem_w_p1;
  assign pc_src     = r_pc_src_p1;
  assign cond_ex    = r_cex_p1;
  assign flags      = r_flags;
  assign squash_cnt = r_squash_cnt;

endmodule
